// File: rtl/button_event_pkg.sv
// Shared register offsets, bus constants and the event FIFO entry layout
// used by button_event_arbiter and its bench.
package button_event_pkg;

    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_POP    = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_CLEAR  = 2'd3;

    localparam logic [1:0]  HTRANS_IDLE = 2'b00;
    localparam logic [31:0] EMPTY_READ  = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [15:0] ts;
        logic [12:0] rsvd;
        logic [2:0]  src;
    } event_entry_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous FIFO with push/pop/flush and occupancy flags; the head entry is
// presented combinationally so a bus read can return and pop it in one cycle.
module event_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign count   = count_reg;
    assign rd_data = mem_reg[rd_ptr_reg];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge HCLK) begin
        if (do_push && !flush) mem_reg[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/button_event_arbiter.sv
// AHB-Lite slave: latches event pulses, arbitrates them round-robin into an event
// FIFO and raises IRQ while it holds entries. BUTTON_EVENT_TIMESTAMP_EN adds timestamps.
module button_event_arbiter
    import button_event_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [31:0]        HADDR,
    input  logic [31:0]        HWDATA,
    input  logic               HWRITE,
    input  logic               HREADY,
    input  logic               HSEL,
    input  logic [2:0]         HSIZE,
    input  logic [1:0]         HTRANS,
    input  logic [NUM_SRC-1:0] EventReq,
    output logic [31:0]        HRDATA,
    output logic               HREADYOUT,
    output logic               IRQ
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic               ap_valid_reg, ap_write_reg;
    logic [1:0]         ap_addr_reg;
    logic               ap_valid_next;
    logic               rd_access, wr_access, flush, clr_err, pop, push;
    logic [NUM_SRC-1:0] pending_reg, pending_next, new_req, grant_vec, drop_hit;
    logic [SRC_W-1:0]   rr_ptr_reg, rr_ptr_next, grant_idx;
    logic               grant_valid, fifo_can_accept, blocked;
    logic [7:0]         mask_reg;
    logic               irq_en_reg, overflow_reg, drop_reg, irq_reg;
    logic [15:0]        wd_cnt_reg;
    logic [15:0]        ts_value;
    event_entry_t       push_entry, head_entry;
    logic [CNT_W-1:0]   fifo_count, count_after;
    logic               fifo_full, fifo_empty;
    logic [3:0]         count_lo;
    logic               unused_ok;

    assign unused_ok = ^{HADDR[31:4], HADDR[1:0], HSIZE, HWDATA[31:9]};

    assign ap_valid_next = HSEL && HREADY && (HTRANS != HTRANS_IDLE);
    assign rd_access     = ap_valid_reg && !ap_write_reg;
    assign wr_access     = ap_valid_reg && ap_write_reg;
    assign flush         = wr_access && (ap_addr_reg == REG_CLEAR) && HWDATA[0];
    assign clr_err       = wr_access && (ap_addr_reg == REG_CLEAR) && HWDATA[1];
    assign pop           = rd_access && (ap_addr_reg == REG_POP) && !fifo_empty;
    assign fifo_can_accept = !fifo_full || pop;
    assign push          = grant_valid;
    assign blocked       = (|pending_reg) && !fifo_can_accept;

    // Round-robin scan starting at rr_ptr; a flush cycle grants nothing.
    always_comb begin
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_SRC;
            if (!grant_valid && pending_reg[SRC_W'(idx)] && fifo_can_accept && !flush) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(idx);
            end
        end
        if (grant_valid) grant_vec[grant_idx] = 1'b1;
    end

    assign rr_ptr_next = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign new_req[gi]      = EventReq[gi] && mask_reg[gi];
            assign pending_next[gi] = !flush && ((pending_reg[gi] && !grant_vec[gi]) || new_req[gi]);
            assign drop_hit[gi]     = !flush && new_req[gi] && pending_reg[gi] && !grant_vec[gi];
        end
    endgenerate

`ifdef BUTTON_EVENT_TIMESTAMP_EN
    logic [4:0]  presc_reg;
    logic [15:0] tick_reg;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            presc_reg <= '0;
            tick_reg  <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
            if (presc_reg == '1) tick_reg <= tick_reg + 1'b1;
        end
    end

    assign ts_value = tick_reg;
`else
    assign ts_value = '0;
`endif

    assign push_entry.ts   = ts_value;
    assign push_entry.rsvd = '0;
    assign push_entry.src  = 3'(grant_idx);

    event_fifo #(
        .WIDTH ($bits(event_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESET  (HRESET),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wr_data (push_entry),
        .rd_data (head_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // IRQ follows the occupancy the FIFO will have after this edge.
    assign count_after = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign count_lo    = 4'(fifo_count);

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ap_valid_reg <= 1'b0;
            ap_write_reg <= 1'b0;
            ap_addr_reg  <= '0;
            pending_reg  <= '0;
            rr_ptr_reg   <= '0;
            mask_reg     <= 8'hFF;
            irq_en_reg   <= 1'b0;
            overflow_reg <= 1'b0;
            drop_reg     <= 1'b0;
            wd_cnt_reg   <= '0;
            irq_reg      <= 1'b0;
        end else begin
            ap_valid_reg <= ap_valid_next;
            ap_write_reg <= ap_valid_next && HWRITE;
            ap_addr_reg  <= ap_valid_next ? HADDR[3:2] : 2'b00;
            pending_reg  <= pending_next;
            if (grant_valid) rr_ptr_reg <= rr_ptr_next;
            if (wr_access && (ap_addr_reg == REG_CTRL)) begin
                mask_reg   <= HWDATA[7:0];
                irq_en_reg <= HWDATA[8];
            end
            if (flush || !blocked) begin
                wd_cnt_reg <= '0;
            end else begin
                wd_cnt_reg <= wd_cnt_reg + 1'b1;
                if (wd_cnt_reg == '1) overflow_reg <= 1'b1;
            end
            if (clr_err) overflow_reg <= 1'b0;
            if (clr_err)        drop_reg <= 1'b0;
            else if (|drop_hit) drop_reg <= 1'b1;
            irq_reg <= irq_en_reg && !flush && (count_after != '0);
        end
    end

    always_comb begin
        HRDATA = '0;
        if (rd_access) begin
            case (ap_addr_reg)
                REG_STATUS: HRDATA = {24'b0, drop_reg, overflow_reg, fifo_full, fifo_empty, count_lo};
                REG_POP:    HRDATA = fifo_empty ? EMPTY_READ : head_entry;
                REG_CTRL:   HRDATA = {23'b0, irq_en_reg, mask_reg};
                default:    HRDATA = '0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign IRQ       = irq_reg;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Self-checking bench for button_event_arbiter: queue-based behavioural model compared
// every cycle, plus directed register-level expectations.
module tb_button_event_arbiter;

    localparam int NS    = 4;
    localparam int DEPTH = 4;

    logic          HCLK = 1'b0;
    logic          HRESET = 1'b1;
    logic [31:0]   HADDR = '0;
    logic [31:0]   HWDATA = '0;
    logic          HWRITE = 1'b0;
    logic          HREADY = 1'b1;
    logic          HSEL = 1'b0;
    logic [2:0]    HSIZE = 3'b010;
    logic [1:0]    HTRANS = 2'b00;
    logic [NS-1:0] EventReq = '0;
    logic [31:0]   HRDATA;
    logic          HREADYOUT;
    logic          IRQ;

    int n_checks = 0;
    int n_err = 0;

    button_event_arbiter #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL), .HSIZE(HSIZE),
        .HTRANS(HTRANS), .EventReq(EventReq), .HRDATA(HRDATA),
        .HREADYOUT(HREADYOUT), .IRQ(IRQ)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [31:0]  m_q[$];
    bit [NS-1:0] m_pend = '0;
    int         m_rr = 0;
    bit [7:0]   m_mask = 8'hFF;
    bit         m_irqen = 0, m_drop = 0, m_ovf = 0, m_irq = 0;
    bit         m_apv = 0, m_apw = 0;
    bit [1:0]   m_apa = 0;
    int         m_wd = 0;
    int         m_edges = 0;

    task automatic model_step();
        bit rd, wr, flush, clr, popped, can;
        bit [NS-1:0] p0;
        bit [15:0] ts;
        int g;
        rd     = m_apv && !m_apw;
        wr     = m_apv && m_apw;
        flush  = wr && (m_apa == 2'd3) && HWDATA[0];
        clr    = wr && (m_apa == 2'd3) && HWDATA[1];
        popped = rd && (m_apa == 2'd1) && (m_q.size() != 0);
        can    = (m_q.size() < DEPTH) || popped;
        p0     = m_pend;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        ts = 16'(m_edges >> 5);
`else
        ts = 16'h0;
`endif
        g = -1;
        if (!flush && can)
            for (int k = 0; k < NS; k++)
                if (g < 0 && p0[(m_rr + k) % NS]) g = (m_rr + k) % NS;
        if (popped) void'(m_q.pop_front());
        if (flush) begin
            m_q.delete();
            m_pend = '0;
        end else begin
            if (g >= 0) begin
                m_q.push_back({ts, 13'b0, 3'(g)});
                m_pend[g] = 1'b0;
                m_rr = (g + 1) % NS;
            end
            for (int i = 0; i < NS; i++)
                if (EventReq[i] && m_mask[i]) begin
                    if (p0[i] && g != i) m_drop = 1'b1;
                    m_pend[i] = 1'b1;
                end
        end
        if (flush || !(p0 != 0 && !can)) m_wd = 0;
        else begin
            if (m_wd == 65535) m_ovf = 1'b1;
            m_wd = (m_wd + 1) & 16'hFFFF;
        end
        if (clr) begin
            m_drop = 1'b0;
            m_ovf  = 1'b0;
        end
        m_irq = m_irqen && (m_q.size() != 0);
        if (wr && m_apa == 2'd2) begin
            m_mask  = HWDATA[7:0];
            m_irqen = HWDATA[8];
        end
        m_apv = HSEL && HREADY && (HTRANS != 2'b00);
        m_apw = m_apv && HWRITE;
        m_apa = m_apv ? HADDR[3:2] : 2'b00;
        m_edges++;
    endtask

    initial forever begin
        @(posedge HCLK or posedge HRESET);
        if (HRESET) begin
            m_q.delete();
            m_pend = '0; m_rr = 0; m_mask = 8'hFF; m_irqen = 0; m_drop = 0;
            m_ovf = 0; m_irq = 0; m_apv = 0; m_apw = 0; m_apa = 0; m_wd = 0; m_edges = 0;
        end else begin
            model_step();
        end
    end

    function automatic bit [31:0] exp_rdata();
        bit full, empty;
        full  = (m_q.size() == DEPTH);
        empty = (m_q.size() == 0);
        if (!(m_apv && !m_apw)) return 32'h0;
        case (m_apa)
            2'd0:    return {24'b0, m_drop, m_ovf, full, empty, 4'(m_q.size())};
            2'd1:    return empty ? 32'hFFFF_FFFF : m_q[0];
            2'd2:    return {23'b0, m_irqen, m_mask};
            default: return 32'h0;
        endcase
    endfunction

    // Per-cycle comparison against the model.
    always @(negedge HCLK) begin
        if (!HRESET) begin
            chk("irq_model", {31'b0, IRQ}, {31'b0, m_irq});
            chk("hreadyout", {31'b0, HREADYOUT}, 32'h1);
            if (m_apv && !m_apw) chk("hrdata_model", HRDATA, exp_rdata());
        end
    end

    // ---------------- bus tasks (entered and left at posedge+1) ----------------
    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge HCLK);
        data = HRDATA;
        $display("rd addr=%h data=%08h", addr[3:0], data);
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = data;
        $display("wr addr=%h data=%08h", addr[3:0], data);
        @(posedge HCLK); #1;
        HWDATA = '0;
    endtask

    task automatic pulse(input logic [NS-1:0] v);
        EventReq = v;
        $display("evt req=%b", v);
        @(posedge HCLK); #1;
        EventReq = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge HCLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d, t1, t2;
        int delta;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Reset state
        chk("reset_irq", {31'b0, IRQ}, 32'h0);
        ahb_read(32'h0, d);  chk("reset_status", d, 32'h0000_0010);
        ahb_read(32'h4, d);  chk("reset_pop_empty", d, 32'hFFFF_FFFF);
        ahb_read(32'h8, d);  chk("reset_ctrl", d, 32'h0000_00FF);

        // Two simultaneous sources, popped in round-robin order
        ahb_write(32'h8, 32'h0000_010F);
        ahb_read(32'h8, d);  chk("ctrl_readback", d, 32'h0000_010F);
        pulse(4'b1010);
        @(negedge HCLK); chk("irq_n1_low", {31'b0, IRQ}, 32'h0);
        @(posedge HCLK);
        @(negedge HCLK); chk("irq_n2_high", {31'b0, IRQ}, 32'h1);
        @(posedge HCLK); #1;
        ahb_read(32'h4, d);  chk("pop_src1", d & 32'hFFFF, 32'h1);
        ahb_read(32'h4, d);  chk("pop_src3", d & 32'hFFFF, 32'h3);
        chk("irq_after_last_pop", {31'b0, IRQ}, 32'h0);
        ahb_read(32'h0, d);  chk("status_empty_again", d, 32'h0000_0010);

        // Fill with source 0; fifth waits pending, sixth is dropped
        for (int i = 0; i < 6; i++) begin
            pulse(4'b0001);
            idle(1);
        end
        idle(3);
        ahb_read(32'h0, d);  chk("status_full_drop", d, 32'h0000_00A4);
        ahb_read(32'h4, d);  chk("pop_full_src0", d & 32'hFFFF, 32'h0);
        ahb_read(32'h0, d);  chk("status_refilled", d, 32'h0000_00A4);
        for (int i = 0; i < 4; i++) begin
            ahb_read(32'h4, d); chk("drain_src0", d & 32'hFFFF, 32'h0);
        end
        ahb_read(32'h0, d);  chk("status_drained", d, 32'h0000_0090);
        ahb_write(32'hC, 32'h0000_0002);
        ahb_read(32'h0, d);  chk("status_drop_cleared", d, 32'h0000_0010);

        // Masked source is ignored silently
        ahb_write(32'h8, 32'h0000_010E);
        pulse(4'b0001);
        idle(3);
        ahb_read(32'h0, d);  chk("status_masked", d, 32'h0000_0010);

        // Fill, leave one pending, then flush everything
        ahb_write(32'h8, 32'h0000_010F);
        pulse(4'b1111);
        idle(6);
        pulse(4'b0001);
        idle(3);
        ahb_read(32'h0, d);  chk("status_full_nodrop", d, 32'h0000_0024);
        ahb_write(32'hC, 32'h0000_0003);
        chk("irq_after_clear", {31'b0, IRQ}, 32'h0);
        ahb_read(32'h0, d);  chk("status_after_clear", d, 32'h0000_0010);
        idle(3);
        ahb_read(32'h0, d);  chk("status_pending_flushed", d, 32'h0000_0010);

        // Timestamped entries 2048 cycles (64 ticks) apart
        pulse(4'b0100);
        idle(3);
        ahb_read(32'h4, t1);
        idle(2048);
        pulse(4'b0100);
        idle(3);
        ahb_read(32'h4, t2);
`ifdef BUTTON_EVENT_TIMESTAMP_EN
        chk("ts_entry1_src", t1 & 32'hFFFF, 32'h2);
        chk("ts_entry2_src", t2 & 32'hFFFF, 32'h2);
        delta = int'(t2[31:16]) - int'(t1[31:16]);
        chk("ts_delta_in_range", {31'b0, (delta >= 63 && delta <= 65)}, 32'h1);
`else
        delta = 0;
        chk("entry1_no_ts", t1, 32'h0000_0002);
        chk("entry2_no_ts", t2, 32'h0000_0002);
`endif
        idle(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
